// File: rtl/palette_fader_if.sv
// Command port of the palette brightness fader: CPU-side set/fade requests.
// Ports: cmd_valid/cmd_ready handshake, cmd_op (2b opcode), cmd_target (8b), abort.
// Master drives the command, slave (the fader) answers with cmd_ready.
interface palette_fader_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_target;
  logic       abort;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_target,
    output abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_target,
    input  abort,
    output cmd_ready
  );
endinterface

// File: rtl/palette_fader.sv
// Frame-synchronous brightness controller feeding the palette lookup stage.
// Latency: SET lands on the first vsync leading edge after acceptance; a fade steps
//   every FRAMES_PER_STEP leading edges, the first step at the FRAMES_PER_STEP-th one.
// Backpressure: cmd_ready is high only while idle; commands offered while busy are dropped.
// Ports: clk, rst_n (async active-low), vsync, host (command interface, slave side),
//   brightness (registered 8b), busy (~cmd_ready), done (1-cycle completion pulse).
module palette_fader #(
  parameter int STEP            = 8,
  parameter int FRAMES_PER_STEP = 2,
  parameter bit VSYNC_ACTIVE    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync,
  palette_fader_if.slave   host,
  output logic [7:0]       brightness,
  output logic             busy,
  output logic             done
);

  localparam logic [8:0] STEP9    = 9'(STEP);
  localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {
    IDLE,
    PEND_SET,
    FADE
  } state_t;

  typedef enum logic [1:0] {
    OP_SET      = 2'b00,
    OP_FADE_TO  = 2'b01,
    OP_FADE_OUT = 2'b10,
    OP_FADE_IN  = 2'b11
  } op_t;

  state_t     state, state_n;
  logic [7:0] target, target_n;
  logic [7:0] frame_cnt, cnt_n;
  logic [7:0] bright_n;
  logic       done_n;
  logic       vs_act, vs_act_q, tick;
  logic       ready;
  logic [8:0] sum, diff;
  logic [7:0] stepped;

  // One tick per sync pulse: only the transition into the active level counts.
  assign vs_act = (vsync == VSYNC_ACTIVE);
  assign tick   = vs_act & ~vs_act_q;

  assign ready          = (state == IDLE);
  assign host.cmd_ready = ready;
  assign busy           = ~ready;

  // 9-bit arithmetic so overshoot past 255 or below 0 is visible and clamps to target.
  assign sum  = {1'b0, brightness} + STEP9;
  assign diff = {1'b0, brightness} - STEP9;

  always_comb begin
    stepped = brightness;
    if (brightness < target) begin
      stepped = (sum >= {1'b0, target}) ? target : sum[7:0];
    end else if (brightness > target) begin
      stepped = (diff[8] || (diff <= {1'b0, target})) ? target : diff[7:0];
    end
  end

  always_comb begin
    state_n  = state;
    target_n = target;
    cnt_n    = frame_cnt;
    bright_n = brightness;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        // abort is meaningless here; a simultaneous command is simply accepted.
        if (host.cmd_valid) begin
          cnt_n = '0;
          case (op_t'(host.cmd_op))
            OP_SET:      target_n = host.cmd_target;
            OP_FADE_TO:  target_n = host.cmd_target;
            OP_FADE_OUT: target_n = 8'h00;
            OP_FADE_IN:  target_n = 8'hFF;
            default:     target_n = host.cmd_target;
          endcase
          state_n = (op_t'(host.cmd_op) == OP_SET) ? PEND_SET : FADE;
        end
      end
      PEND_SET: begin
        // abort outranks a completing tick: brightness holds, no done.
        if (host.abort) begin
          state_n = IDLE;
        end else if (tick) begin
          bright_n = target;
          done_n   = 1'b1;
          state_n  = IDLE;
        end
      end
      FADE: begin
        if (host.abort) begin
          state_n = IDLE;
        end else if (tick) begin
          if (frame_cnt == CNT_LAST) begin
            cnt_n    = '0;
            bright_n = stepped;
            if (stepped == target) begin
              done_n  = 1'b1;
              state_n = IDLE;
            end
          end else begin
            cnt_n = frame_cnt + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      target     <= 8'hFF;
      frame_cnt  <= '0;
      brightness <= 8'hFF;
      done       <= 1'b0;
      vs_act_q   <= 1'b0;
    end else begin
      state      <= state_n;
      target     <= target_n;
      frame_cnt  <= cnt_n;
      brightness <= bright_n;
      done       <= done_n;
      vs_act_q   <= vs_act;
    end
  end

endmodule
